// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants, fetch-state enum and IF/ID record
package pipe_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        DONE  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam int IF_ID_W = $bits(if_id_t);

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic if_id_t if_id_bubble(input logic [31:0] nop);
        if_id_t b;
        b.instr    = nop;
        b.pc_plus4 = 32'h0;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - generic pipeline register with hold and flush controls
module if_id_reg #(
    parameter int              W           = 65,
    parameter logic [W-1:0]    CLEAR_VALUE = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          flush,
    input  logic [W-1:0]  d,
    output logic [W-1:0]  q
);

    // Flush beats hold so a redirect can kill a stalled instruction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= CLEAR_VALUE;
        end else if (flush) begin
            q <= CLEAR_VALUE;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS instruction-fetch stage; IF_FETCH_PERF_CNT_EN adds fetch/stall counters
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = pipe_pkg::RESET_PC,
    parameter int          IMEM_BYTES = 36,
    parameter logic [31:0] NOP_WORD   = pipe_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] Instruction_Code,
    output logic [31:0] PC,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
`ifdef IF_FETCH_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic        fetch_done
);

    import pipe_pkg::*;

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    fetch_state_t state;
    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_target;
    logic         redirect_in_range;
    if_id_t       if_id_d;
    if_id_t       if_id_q;

    assign pc_plus4          = PC + 32'd4;
    assign redirect_target   = word_align(redirect_pc);
    assign redirect_in_range = (redirect_target <= LAST_PC);

    // PC and state: reset > redirect > stall > advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            PC         <= RESET_PC;
            state      <= FETCH;
            fetch_done <= 1'b0;
        end else if (redirect_valid) begin
            if (redirect_in_range) begin
                PC         <= redirect_target;
                state      <= FETCH;
                fetch_done <= 1'b0;
            end else begin
                state      <= DONE;
                fetch_done <= 1'b1;
            end
        end else if (!stall && state == FETCH) begin
            if (PC < LAST_PC) begin
                PC <= pc_plus4;
            end else begin
                state      <= DONE;
                fetch_done <= 1'b1;
            end
        end
    end

    always_comb begin
        if_id_d = if_id_bubble(NOP_WORD);
        if (state == FETCH) begin
            if_id_d.instr    = Instruction_Code;
            if_id_d.pc_plus4 = pc_plus4;
            if_id_d.valid    = 1'b1;
        end
    end

    if_id_reg #(
        .W           (IF_ID_W),
        .CLEAR_VALUE (if_id_bubble(NOP_WORD))
    ) u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .hold  (stall),
        .flush (redirect_valid),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign if_id_instr    = if_id_q.instr;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign if_id_valid    = if_id_q.valid;

`ifdef IF_FETCH_PERF_CNT_EN
    logic fetch_event;
    logic stall_event;

    assign fetch_event = !redirect_valid && !stall && (state == FETCH);
    assign stall_event = !redirect_valid &&  stall && (state == FETCH);

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            if (fetch_event && fetch_count != 32'hFFFF_FFFF) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (stall_event && stall_count != 32'hFFFF_FFFF) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule
